controller_v2: RTL
==================

# controller_v2

Parametrised multicycle RV32I main-control FSM, successor to the first-generation controller. It sits between the instruction register and the datapath of the multicycle core. It decodes opcode/funct fields into per-state datapath controls and adds a ready/valid memory handshake with timeout. It also supports an optional multi-cycle M-extension execute state and a sticky error vector that the toplevel drives to LEDs/seven-segment for debug.

## Interface
- `ENABLE_M`, 0: 1 accepts R-type funct7=0000001 and routes it through S_MULDIV; 0 flags it illegal.
- `WAIT_MAX`, 15: max consecutive not-ready cycles tolerated in any wait state; ≥1.
- `CNT_W`, $clog2(WAIT_MAX+1): wait-counter width.
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `opcode` in 7: instruction register bits [6:0].
- `funct3` in 3: IR [14:12].
- `funct7` in 7: IR [31:25].
- `mem_ready` in 1: memory completes current access this cycle.
- `muldiv_done` in 1: mul/div unit result valid; ignored when ENABLE_M=0.
- `pc_write` out 1: PC register load enable.
- `ir_write` out 1: IR/old-PC load enable.
- `mem_read` out 1: read request.
- `mem_write` out 1: write request.
- `adr_src` out 1: 0=PC, 1=ALUOut.
- `reg_write` out 1: register file write enable.
- `alu_src_a` out 2: 0=PC, 1=OLDPC, 2=RS1.
- `alu_src_b` out 2: 0=RS2, 1=IMM, 2=FOUR.
- `result_src` out 2: 0=ALUOut, 1=MEMDATA, 2=ALU result.
- `alu_op` out 2: 0=add, 1=sub, 2=funct-decode.
- `branch` out 1: PC write if ALU zero-condition met.
- `muldiv_start` out 1: one-cycle start pulse.
- `current_state_vector` out 5: state register.
- `next_state_vector` out 5: combinational next state.
- `error_vector` out 8: sticky error flags.

## Operation
- States: S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_LUI, S_AUIPC, S_MULDIV, S_TRAP.
- FETCH: mem_read=1, adr_src=0, src_a=PC, src_b=FOUR, alu_op=add. Holds until mem_ready=1. In that cycle, ir_write=pc_write=1 and the FSM moves to DECODE.
- DECODE (opcode): 0000011→MEMADR; 0100011→MEMADR; 0110011→EXECR, or MULDIV if funct7=0000001 and ENABLE_M; 0010011→EXECI; 1100011→BRANCH; 1101111→JAL; 1100111→JALR; 0110111→LUI; 0010111→AUIPC; other→TRAP.
- MEMADR→MEMREAD (load) or MEMWRITE (store).
- MEMREAD holds until mem_ready, then →MEMWB.
- MEMWRITE holds until mem_ready, then →FETCH.
- EXECR/EXECI/JAL/JALR/LUI/AUIPC→ALUWB→FETCH. JAL/JALR assert pc_write.
- BRANCH→FETCH.
- MULDIV: muldiv_start=1 on the entry cycle only. Holds until muldiv_done, then →ALUWB.
- Wait counter: cleared on entry to any wait state (FETCH, MEMREAD, MEMWRITE, MULDIV). Increments each cycle ready/done is low.
- Timeout: ready/done low for WAIT_MAX+1 consecutive cycles forces next state TRAP. Ready arriving on the threshold cycle wins.
- TRAP: all enables 0. Absorbing; only rst exits.
- error_vector bits:
  - [0] illegal opcode.
  - [1] illegal R-type funct7 (not 0000000/0100000, or 0000001 with ENABLE_M=0).
  - [2] fetch timeout.
  - [3] data-memory timeout.
  - [4] muldiv timeout.
  - [5] unreachable state encoding reached (FSM then →TRAP).
  - [6] reserved, 0.
  - [7] OR of [5:0].
  - Bits set in the cycle the condition is registered and stay set until rst.

## Timing
- Reset: state=S_FETCH, counter=0, error_vector=0. Outputs equal the FETCH decode: mem_read=1, src_b=FOUR, all write enables 0 unless mem_ready=1.
- Outputs are Moore from the state register, except ir_write/pc_write in FETCH, which are gated by mem_ready (same cycle).
- Zero-wait latency: R/I/JAL/JALR/LUI/AUIPC 4 cycles, load 5, store 4, branch 3, muldiv 4+done latency.
- rst mid-instruction: FETCH on the next edge; any in-flight request is abandoned.

## Structure
- Package `controller_pkg`: state enum (5-bit), alu_src_a/b, result_src and alu_op enums, opcode constants, error-bit index constants.
- One sub-module, `wait_timer`: counter with clear, enable and terminal-count flag, parametrised by WAIT_MAX.
- Next-state logic, output decode and error register live in controller_v2.

## Test plan
- rst=1 for 2 cycles, mem_ready=0 → state=S_FETCH, error_vector=8'h00, mem_read=1, ir_write=0.
- add (0110011, funct7=0), mem_ready=1 → FETCH, DECODE, EXECR, ALUWB, FETCH; reg_write=1 only in ALUWB.
- Load with mem_ready low 3 cycles in MEMREAD → MEMREAD held 4 cycles, then MEMWB with result_src=1. Total 8 cycles.
- mem_ready=0 for WAIT_MAX+1=16 cycles in FETCH → TRAP, error_vector=8'h84. Stays latched until rst, then clears.
- opcode 7'b1111111 → DECODE→TRAP, error_vector=8'h81.
- funct7=0000001: ENABLE_M=0 → TRAP with error_vector=8'h82. ENABLE_M=1 → MULDIV, one start pulse; done after 5 cycles → ALUWB.

Source files
------------

// File: rtl/controller_v2_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : controller_pkg
//  Description : Shared types and constants for the controller_v2 multicycle
//                RV32I main-control FSM: state encoding, datapath mux select
//                encodings, opcode / funct7 constants and error-bit indices.
//  Revision    : 1.0 - initial release
// ============================================================================
package controller_pkg;

  // 16 legal states in a 5-bit register; encodings 16..31 are unreachable.
  typedef enum logic [4:0] {
    S_FETCH    = 5'd0,
    S_DECODE   = 5'd1,
    S_MEMADR   = 5'd2,
    S_MEMREAD  = 5'd3,
    S_MEMWB    = 5'd4,
    S_MEMWRITE = 5'd5,
    S_EXECR    = 5'd6,
    S_EXECI    = 5'd7,
    S_ALUWB    = 5'd8,
    S_BRANCH   = 5'd9,
    S_JAL      = 5'd10,
    S_JALR     = 5'd11,
    S_LUI      = 5'd12,
    S_AUIPC    = 5'd13,
    S_MULDIV   = 5'd14,
    S_TRAP     = 5'd15
  } state_e;

  typedef enum logic [1:0] {
    SRCA_PC    = 2'd0,
    SRCA_OLDPC = 2'd1,
    SRCA_RS1   = 2'd2
  } alu_src_a_e;

  typedef enum logic [1:0] {
    SRCB_RS2  = 2'd0,
    SRCB_IMM  = 2'd1,
    SRCB_FOUR = 2'd2
  } alu_src_b_e;

  typedef enum logic [1:0] {
    RES_ALUOUT  = 2'd0,
    RES_MEMDATA = 2'd1,
    RES_ALU     = 2'd2
  } result_src_e;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'd0,
    ALUOP_SUB   = 2'd1,
    ALUOP_FUNCT = 2'd2
  } alu_op_e;

  // RV32I major opcodes
  localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
  localparam logic [6:0] c_OP_STORE  = 7'b0100011;
  localparam logic [6:0] c_OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] c_OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
  localparam logic [6:0] c_OP_JAL    = 7'b1101111;
  localparam logic [6:0] c_OP_JALR   = 7'b1100111;
  localparam logic [6:0] c_OP_LUI    = 7'b0110111;
  localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;

  // R-type funct7 values
  localparam logic [6:0] c_F7_BASE   = 7'b0000000;
  localparam logic [6:0] c_F7_ALT    = 7'b0100000;
  localparam logic [6:0] c_F7_MULDIV = 7'b0000001;

  // error_vector bit positions ([6] reserved, [7] summary)
  localparam int c_ERR_ILLEGAL_OP  = 0;
  localparam int c_ERR_ILLEGAL_F7  = 1;
  localparam int c_ERR_FETCH_TO    = 2;
  localparam int c_ERR_DMEM_TO     = 3;
  localparam int c_ERR_MULDIV_TO   = 4;
  localparam int c_ERR_BAD_STATE   = 5;

  // States that wait on an external ready/done and run the timeout counter.
  function automatic logic is_wait_state(input state_e s);
    return (s == S_FETCH) || (s == S_MEMREAD) || (s == S_MEMWRITE) || (s == S_MULDIV);
  endfunction

endpackage
`default_nettype wire

// File: rtl/controller_v2_wait_timer.sv
`default_nettype none
// ============================================================================
//  Module      : wait_timer
//  Description : Consecutive not-ready cycle counter. Clear has priority over
//                enable; o_tc flags that WAIT_MAX low cycles have already been
//                counted, i.e. the current low cycle is the (WAIT_MAX+1)-th.
//  Ports       : clk, rst      - clock, synchronous active-high reset
//                i_clr         - zero the counter (state transition)
//                i_en          - count this cycle (ready/done low)
//                o_count       - current count
//                o_tc          - terminal count reached
//  Revision    : 1.0 - initial release
// ============================================================================
module wait_timer #(
  parameter int WAIT_MAX = 15,
  parameter int CNT_W    = $clog2(WAIT_MAX + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_count,
  output logic             o_tc
);

  localparam logic [CNT_W-1:0] c_TC_VAL = CNT_W'(WAIT_MAX);

  logic [CNT_W-1:0] r_count;

  // The FSM leaves the wait state on terminal count, so holding at c_TC_VAL
  // only guards against wrap if the counter is ever enabled past it.
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_count <= '0;
    end else if (i_en && !o_tc) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_count = r_count;
  assign o_tc    = (r_count == c_TC_VAL);

endmodule
`default_nettype wire

// File: rtl/controller_v2.sv
`default_nettype none
// ============================================================================
//  Module      : controller_v2
//  Description : Multicycle RV32I main-control FSM with ready/valid memory
//                handshake, wait-state timeout, optional M-extension execute
//                state and a sticky debug error vector.
//  Ports       : clk, rst               - clock, synchronous active-high reset
//                i_opcode/funct3/funct7 - instruction register fields
//                i_mem_ready            - memory completes access this cycle
//                i_muldiv_done          - mul/div result valid
//                o_pc_write .. o_branch - per-state datapath controls
//                o_muldiv_start         - one-cycle start pulse
//                o_current/next_state_vector - FSM state for debug
//                o_error_vector         - sticky error flags, [7] = summary
//  Revision    : 1.0 - initial release
// ============================================================================
module controller_v2
  import controller_pkg::*;
#(
  parameter int ENABLE_M = 0,
  parameter int WAIT_MAX = 15,
  parameter int CNT_W    = $clog2(WAIT_MAX + 1)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] i_opcode,
  input  logic [2:0] i_funct3,
  input  logic [6:0] i_funct7,
  input  logic       i_mem_ready,
  input  logic       i_muldiv_done,
  output logic       o_pc_write,
  output logic       o_ir_write,
  output logic       o_mem_read,
  output logic       o_mem_write,
  output logic       o_adr_src,
  output logic       o_reg_write,
  output logic [1:0] o_alu_src_a,
  output logic [1:0] o_alu_src_b,
  output logic [1:0] o_result_src,
  output logic [1:0] o_alu_op,
  output logic       o_branch,
  output logic       o_muldiv_start,
  output logic [4:0] o_current_state_vector,
  output logic [4:0] o_next_state_vector,
  output logic [7:0] o_error_vector
);

  state_e           r_state;
  state_e           w_next;
  logic [5:0]       r_err;
  logic [5:0]       w_err_set;
  logic             w_rdy;
  logic             w_tc;
  logic             w_clr;
  logic             w_en;
  logic [CNT_W-1:0] w_count;

  // funct3 is resolved by the datapath ALU decoder, not by this FSM.
  logic w_unused_funct3;
  assign w_unused_funct3 = ^i_funct3;

  // Ready/done source for whichever wait state is active.
  always_comb begin
    w_rdy = 1'b1;
    case (r_state)
      S_FETCH, S_MEMREAD, S_MEMWRITE: w_rdy = i_mem_ready;
      S_MULDIV:                       w_rdy = i_muldiv_done;
      default:                        w_rdy = 1'b1;
    endcase
  end

  // Any state change restarts the count, so every wait state is entered at 0.
  assign w_clr = (w_next != r_state);
  assign w_en  = is_wait_state(r_state) && !w_rdy;

  wait_timer #(
    .WAIT_MAX (WAIT_MAX),
    .CNT_W    (CNT_W)
  ) u_wait_timer (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (w_clr),
    .i_en    (w_en),
    .o_count (w_count),
    .o_tc    (w_tc)
  );

  // --------------------------------------------------------------------------
  // Next-state logic and error capture
  // --------------------------------------------------------------------------
  always_comb begin
    w_next    = r_state;
    w_err_set = '0;
    case (r_state)
      S_FETCH: begin
        if (i_mem_ready) begin
          w_next = S_DECODE;
        end else if (w_tc) begin
          w_next                    = S_TRAP;
          w_err_set[c_ERR_FETCH_TO] = 1'b1;
        end
      end
      S_DECODE: begin
        case (i_opcode)
          c_OP_LOAD, c_OP_STORE: w_next = S_MEMADR;
          c_OP_RTYPE: begin
            if (i_funct7 == c_F7_BASE || i_funct7 == c_F7_ALT) begin
              w_next = S_EXECR;
            end else if (i_funct7 == c_F7_MULDIV && ENABLE_M != 0) begin
              w_next = S_MULDIV;
            end else begin
              w_next                      = S_TRAP;
              w_err_set[c_ERR_ILLEGAL_F7] = 1'b1;
            end
          end
          c_OP_ITYPE:  w_next = S_EXECI;
          c_OP_BRANCH: w_next = S_BRANCH;
          c_OP_JAL:    w_next = S_JAL;
          c_OP_JALR:   w_next = S_JALR;
          c_OP_LUI:    w_next = S_LUI;
          c_OP_AUIPC:  w_next = S_AUIPC;
          default: begin
            w_next                      = S_TRAP;
            w_err_set[c_ERR_ILLEGAL_OP] = 1'b1;
          end
        endcase
      end
      // The IR still holds the instruction, so the opcode picks load vs store.
      S_MEMADR:   w_next = (i_opcode == c_OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD: begin
        if (i_mem_ready) begin
          w_next = S_MEMWB;
        end else if (w_tc) begin
          w_next                   = S_TRAP;
          w_err_set[c_ERR_DMEM_TO] = 1'b1;
        end
      end
      S_MEMWB:    w_next = S_FETCH;
      S_MEMWRITE: begin
        if (i_mem_ready) begin
          w_next = S_FETCH;
        end else if (w_tc) begin
          w_next                   = S_TRAP;
          w_err_set[c_ERR_DMEM_TO] = 1'b1;
        end
      end
      S_EXECR, S_EXECI, S_JAL, S_JALR, S_LUI, S_AUIPC: w_next = S_ALUWB;
      S_ALUWB:    w_next = S_FETCH;
      S_BRANCH:   w_next = S_FETCH;
      S_MULDIV: begin
        if (i_muldiv_done) begin
          w_next = S_ALUWB;
        end else if (w_tc) begin
          w_next                     = S_TRAP;
          w_err_set[c_ERR_MULDIV_TO] = 1'b1;
        end
      end
      S_TRAP:     w_next = S_TRAP;
      default: begin
        w_next                     = S_TRAP;
        w_err_set[c_ERR_BAD_STATE] = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_FETCH;
      r_err   <= '0;
    end else begin
      r_state <= w_next;
      r_err   <= r_err | w_err_set;
    end
  end

  // --------------------------------------------------------------------------
  // Output decode (Moore, except the FETCH load enables)
  // --------------------------------------------------------------------------
  always_comb begin
    o_pc_write     = 1'b0;
    o_ir_write     = 1'b0;
    o_mem_read     = 1'b0;
    o_mem_write    = 1'b0;
    o_adr_src      = 1'b0;
    o_reg_write    = 1'b0;
    o_alu_src_a    = SRCA_PC;
    o_alu_src_b    = SRCB_RS2;
    o_result_src   = RES_ALUOUT;
    o_alu_op       = ALUOP_ADD;
    o_branch       = 1'b0;
    o_muldiv_start = 1'b0;
    case (r_state)
      S_FETCH: begin
        o_mem_read   = 1'b1;
        o_alu_src_b  = SRCB_FOUR;
        o_result_src = RES_ALU;
        // IR and PC load in the same cycle the memory returns the word.
        o_ir_write   = i_mem_ready;
        o_pc_write   = i_mem_ready;
      end
      S_DECODE: begin
        // Branch/JAL target OLDPC+imm is precomputed into ALUOut.
        o_alu_src_a = SRCA_OLDPC;
        o_alu_src_b = SRCB_IMM;
      end
      S_MEMADR: begin
        o_alu_src_a = SRCA_RS1;
        o_alu_src_b = SRCB_IMM;
      end
      S_MEMREAD: begin
        o_mem_read = 1'b1;
        o_adr_src  = 1'b1;
      end
      S_MEMWB: begin
        o_result_src = RES_MEMDATA;
        o_reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        o_mem_write = 1'b1;
        o_adr_src   = 1'b1;
      end
      S_EXECR: begin
        o_alu_src_a = SRCA_RS1;
        o_alu_op    = ALUOP_FUNCT;
      end
      S_EXECI: begin
        o_alu_src_a = SRCA_RS1;
        o_alu_src_b = SRCB_IMM;
        o_alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        o_reg_write = 1'b1;
      end
      S_BRANCH: begin
        o_alu_src_a = SRCA_RS1;
        o_alu_op    = ALUOP_SUB;
        o_branch    = 1'b1;
      end
      S_JAL: begin
        // PC takes the DECODE-time target from ALUOut while the ALU forms
        // the link value OLDPC+4 for ALUWB.
        o_alu_src_a = SRCA_OLDPC;
        o_alu_src_b = SRCB_FOUR;
        o_pc_write  = 1'b1;
      end
      S_JALR: begin
        o_alu_src_a  = SRCA_RS1;
        o_alu_src_b  = SRCB_IMM;
        o_result_src = RES_ALU;
        o_pc_write   = 1'b1;
      end
      S_LUI: begin
        // The ALU decoder passes operand B straight through for LUI.
        o_alu_src_b = SRCB_IMM;
        o_alu_op    = ALUOP_FUNCT;
      end
      S_AUIPC: begin
        o_alu_src_a = SRCA_OLDPC;
        o_alu_src_b = SRCB_IMM;
      end
      S_MULDIV: begin
        o_alu_src_a    = SRCA_RS1;
        // Counter is zero only on the entry cycle: any stay increments it.
        o_muldiv_start = (w_count == '0);
      end
      default: ;
    endcase
  end

  assign o_current_state_vector = r_state;
  assign o_next_state_vector    = w_next;
  assign o_error_vector         = {(|r_err), 1'b0, r_err};

endmodule
`default_nettype wire
